signed_divider: RTL and testbench

- Multi-cycle 8-bit signed integer divider for the ALU; the inverse operation to the combinational signed multiplier.
- Uses restoring division on magnitudes, one quotient bit per clock, followed by a sign-fixup cycle.
- Sits beside the multiplier in the ALU. The controller stalls the CPU on BUSY and captures results on DONE.
- Results truncate toward zero, matching two's-complement operand conventions.

---
 rtl/signed_divider_pkg.sv | 19 +
 rtl/abs_value.sv | 19 +
 rtl/signed_divider.sv | 163 ++++++++++++++++
 tb/tb_signed_divider.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/signed_divider_pkg.sv
// Shared ALU divider definitions: FSM state encoding, iteration count and the
// quotient returned for a zero divisor.
package signed_divider_pkg;

   localparam int ALU_WIDTH = 8;

   // One quotient bit per CALC cycle.
   localparam int DIV_ITER = ALU_WIDTH;

   // All-ones quotient reported when dividing by zero.
   localparam logic [ALU_WIDTH-1:0] DIV_ZERO_QUOT = 8'hFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } div_state_t;

endpackage

// File: rtl/abs_value.sv
// Two's-complement magnitude of a signed operand.
//   value     : WIDTH-bit two's-complement input
//   magnitude : WIDTH+1-bit unsigned magnitude (the most negative value maps
//               to 2**(WIDTH-1), which does not fit in WIDTH signed bits)
module abs_value #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] value,
   output logic [WIDTH:0]   magnitude
);

   logic [WIDTH:0] ext;

   always_comb begin
      ext       = {value[WIDTH-1], value};
      magnitude = value[WIDTH-1] ? (~ext + 1'b1) : ext;
   end

endmodule

// File: rtl/signed_divider.sv
// Multi-cycle signed integer divider for the ALU.
// Restoring division on operand magnitudes, one quotient bit per clock,
// followed by a single sign-fixup cycle. Results truncate toward zero and the
// remainder takes the sign of the dividend.
//
// Ports:
//   CLK         : rising-edge clock
//   RESET       : asynchronous active-low reset, aborts any division
//   START       : request pulse, only sampled while idle
//   DATA1       : dividend, two's complement
//   DATA2       : divisor, two's complement
//   QUOTIENT    : signed quotient, registered
//   REMAINDER   : signed remainder, registered
//   BUSY        : high while a division is in progress
//   DONE        : one-cycle pulse when results are valid
//   DIV_BY_ZERO : last operation had a zero divisor
//   OVERFLOW    : last operation was most-negative / -1
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for START; zero divisor answered directly from here
// CALC  | WIDTH shift/trial-subtract steps on the latched magnitudes
// FIX   | apply result signs, raise DONE, return to IDLE
module signed_divider
   import signed_divider_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             START,
   input  logic [WIDTH-1:0] DATA1,
   input  logic [WIDTH-1:0] DATA2,
   output logic [WIDTH-1:0] QUOTIENT,
   output logic [WIDTH-1:0] REMAINDER,
   output logic             BUSY,
   output logic             DONE,
   output logic             DIV_BY_ZERO,
   output logic             OVERFLOW
);

   localparam int CNT_W = $clog2(DIV_ITER) + 1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_ITER - 1);
   localparam logic [WIDTH-1:0] Q_LIMIT = {1'b1, {(WIDTH-1){1'b0}}};

   div_state_t       state;
   logic [WIDTH:0]   mag_a;
   logic [WIDTH:0]   mag_b;
   logic [WIDTH:0]   divisor;
   // Dividend bits shift out of the top while quotient bits shift in at
   // the bottom, so after WIDTH steps this register holds the magnitude
   // quotient.
   logic [WIDTH-1:0] dvd_q;
   // Remainder is always below the divisor magnitude (<= 2**(WIDTH-1)),
   // so WIDTH bits are enough to hold it between steps.
   logic [WIDTH-1:0] part_rem;
   logic [CNT_W-1:0] cnt;
   logic             qsign;
   logic             rsign;
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH:0]   trial;
   logic             mag_a_top_unused;

   abs_value #(.WIDTH(WIDTH)) u_abs_dividend (
      .value     (DATA1),
      .magnitude (mag_a)
   );

   abs_value #(.WIDTH(WIDTH)) u_abs_divisor (
      .value     (DATA2),
      .magnitude (mag_b)
   );

   // The dividend magnitude never exceeds 2**(WIDTH-1), which is already
   // representable as an unsigned WIDTH-bit value, so its top bit is redundant.
   assign mag_a_top_unused = mag_a[WIDTH];

   // rem_shift peaks at 2*(2**(WIDTH-1)-1)+1 and the divisor at 2**(WIDTH-1),
   // so the WIDTH+1-bit difference has an unambiguous sign in its top bit.
   always_comb begin
      rem_shift = {part_rem, dvd_q[WIDTH-1]};
      trial     = rem_shift - divisor;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state       <= IDLE;
         QUOTIENT    <= '0;
         REMAINDER   <= '0;
         BUSY        <= 1'b0;
         DONE        <= 1'b0;
         DIV_BY_ZERO <= 1'b0;
         OVERFLOW    <= 1'b0;
         divisor     <= '0;
         dvd_q       <= '0;
         part_rem    <= '0;
         cnt         <= '0;
         qsign       <= 1'b0;
         rsign       <= 1'b0;
      end else begin
         DONE <= 1'b0;
         case (state)
            IDLE: begin
               if (START) begin
                  if (DATA2 == '0) begin
                     QUOTIENT    <= DIV_ZERO_QUOT;
                     REMAINDER   <= DATA1;
                     DIV_BY_ZERO <= 1'b1;
                     OVERFLOW    <= 1'b0;
                     DONE        <= 1'b1;
                  end else begin
                     dvd_q       <= mag_a[WIDTH-1:0];
                     divisor     <= mag_b;
                     part_rem    <= '0;
                     cnt         <= '0;
                     qsign       <= DATA1[WIDTH-1] ^ DATA2[WIDTH-1];
                     rsign       <= DATA1[WIDTH-1];
                     DIV_BY_ZERO <= 1'b0;
                     OVERFLOW    <= 1'b0;
                     BUSY        <= 1'b1;
                     state       <= CALC;
                  end
               end
            end

            CALC: begin
               if (trial[WIDTH]) begin
                  // Trial went negative: keep the shifted remainder.
                  // A restore only happens when rem_shift < divisor, so
                  // its top bit is zero here.
                  part_rem <= rem_shift[WIDTH-1:0];
                  dvd_q    <= {dvd_q[WIDTH-2:0], 1'b0};
               end else begin
                  part_rem <= trial[WIDTH-1:0];
                  dvd_q    <= {dvd_q[WIDTH-2:0], 1'b1};
               end
               cnt <= cnt + 1'b1;
               if (cnt == LAST_ITER) begin
                  state <= FIX;
               end
            end

            FIX: begin
               // A magnitude quotient of 2**(WIDTH-1) negates onto itself,
               // so the most-negative result needs no special case; only a
               // positive one is unrepresentable.
               QUOTIENT  <= qsign ? (~dvd_q + 1'b1) : dvd_q;
               REMAINDER <= rsign ? (~part_rem + 1'b1) : part_rem;
               OVERFLOW  <= (dvd_q == Q_LIMIT) && !qsign;
               DONE      <= 1'b1;
               BUSY      <= 1'b0;
               state     <= IDLE;
            end

            default: begin
               BUSY  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_signed_divider.sv
module tb_signed_divider;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       START = 1'b0;
   logic [7:0] DATA1 = 8'h00;
   logic [7:0] DATA2 = 8'h00;
   logic [7:0] QUOTIENT;
   logic [7:0] REMAINDER;
   logic       BUSY;
   logic       DONE;
   logic       DIV_BY_ZERO;
   logic       OVERFLOW;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   signed_divider #(.WIDTH(8)) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .START       (START),
      .DATA1       (DATA1),
      .DATA2       (DATA2),
      .QUOTIENT    (QUOTIENT),
      .REMAINDER   (REMAINDER),
      .BUSY        (BUSY),
      .DONE        (DONE),
      .DIV_BY_ZERO (DIV_BY_ZERO),
      .OVERFLOW    (OVERFLOW)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] q;
      logic [7:0] r;
      logic       dbz;
      logic       ov;
      int         lat;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   // Reference: plain signed integer arithmetic (truncating division).
   task automatic model(input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] q, output logic [7:0] r,
                        output logic dbz, output logic ov, output int lat);
      int sa, sb, qi, ri;
      sa  = $signed(a);
      sb  = $signed(b);
      dbz = 1'b0;
      ov  = 1'b0;
      if (sb == 0) begin
         q   = 8'hFF;
         r   = a;
         dbz = 1'b1;
         lat = 0;
      end else begin
         qi  = sa / sb;
         ri  = sa % sb;
         ov  = (qi > 127);
         q   = qi[7:0];
         r   = ri[7:0];
         lat = 9;
      end
   endtask

   // Waits (bounded) for DONE, sampling on falling edges. lat counts rising
   // edges after the start edge; busy_cnt counts cycles with BUSY high.
   task automatic wait_done(output int lat, output int busy_cnt, input bit scramble);
      lat      = 0;
      busy_cnt = 0;
      while (!DONE && lat < 30) begin
         if (BUSY) busy_cnt++;
         if (scramble) begin
            DATA1 = 8'($urandom);
            DATA2 = 8'($urandom);
            START = 1'($urandom);
         end
         @(negedge CLK);
         lat++;
      end
      START = 1'b0;
      check("done_timeout", int'(DONE), 1);
   endtask

   task automatic run_div(input logic [7:0] a, input logic [7:0] b, input bit scramble,
                          output int lat, output int busy_cnt);
      @(negedge CLK);
      DATA1 = a;
      DATA2 = b;
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      wait_done(lat, busy_cnt, scramble);
   endtask

   task automatic check_result(input string tag, input logic [7:0] eq, input logic [7:0] er,
                               input logic edbz, input logic eov);
      check({tag, "_quotient"}, int'(QUOTIENT), int'(eq));
      check({tag, "_remainder"}, int'(REMAINDER), int'(er));
      check({tag, "_div_by_zero"}, int'(DIV_BY_ZERO), int'(edbz));
      check({tag, "_overflow"}, int'(OVERFLOW), int'(eov));
   endtask

   initial begin
      int lat, busy_cnt, done_seen;
      logic [7:0] eq, er, a, b;
      logic edbz, eov;
      int elat;

      vecs[0]  = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 1'b0, 9};
      vecs[1]  = '{8'h9C,  8'd7,   8'hF2,  8'hFE,  1'b0, 1'b0, 9};
      vecs[2]  = '{8'd100, 8'hF9,  8'hF2,  8'h02,  1'b0, 1'b0, 9};
      vecs[3]  = '{8'h80,  8'hFF,  8'h80,  8'h00,  1'b0, 1'b1, 9};
      vecs[4]  = '{8'h80,  8'h01,  8'h80,  8'h00,  1'b0, 1'b0, 9};
      vecs[5]  = '{8'h05,  8'h00,  8'hFF,  8'h05,  1'b1, 1'b0, 0};
      vecs[6]  = '{8'h80,  8'hFF,  8'h80,  8'h00,  1'b0, 1'b1, 9};
      vecs[7]  = '{8'h80,  8'h00,  8'hFF,  8'h80,  1'b1, 1'b0, 0};
      vecs[8]  = '{8'h7F,  8'h80,  8'h00,  8'h7F,  1'b0, 1'b0, 9};
      vecs[9]  = '{8'h80,  8'h80,  8'h01,  8'h00,  1'b0, 1'b0, 9};
      vecs[10] = '{8'h00,  8'd5,   8'h00,  8'h00,  1'b0, 1'b0, 9};
      vecs[11] = '{8'hF9,  8'd2,   8'hFD,  8'hFF,  1'b0, 1'b0, 9};

      // Reset state
      #1 RESET = 1'b0;
      #1;
      check("rst_quotient", int'(QUOTIENT), 0);
      check("rst_remainder", int'(REMAINDER), 0);
      check("rst_busy", int'(BUSY), 0);
      check("rst_done", int'(DONE), 0);
      check("rst_flags", int'({DIV_BY_ZERO, OVERFLOW}), 0);
      @(negedge CLK);
      @(negedge CLK);
      RESET = 1'b1;

      // Directed table
      for (int i = 0; i < 12; i++) begin
         run_div(vecs[i].a, vecs[i].b, 1'b0, lat, busy_cnt);
         check_result($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].ov);
         check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
         check($sformatf("vec%0d_busy_cycles", i), busy_cnt, vecs[i].lat);
         @(negedge CLK);
         check($sformatf("vec%0d_done_pulse", i), int'(DONE), 0);
         check($sformatf("vec%0d_hold_q", i), int'(QUOTIENT), int'(vecs[i].q));
      end

      // START during CALC is ignored
      @(negedge CLK);
      DATA1 = 8'd50; DATA2 = 8'd3; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      DATA1 = 8'd9; DATA2 = 8'd2; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      wait_done(lat, busy_cnt, 1'b0);
      check_result("ignore_start", 8'd16, 8'd2, 1'b0, 1'b0);

      // New START in the DONE cycle is accepted
      DATA1 = 8'hEC; DATA2 = 8'd3; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      check("b2b_busy", int'(BUSY), 1);
      check("b2b_done_low", int'(DONE), 0);
      wait_done(lat, busy_cnt, 1'b0);
      check_result("b2b", 8'hFA, 8'hFE, 1'b0, 1'b0);
      check("b2b_latency", lat, 9);

      // Reset mid-operation
      @(negedge CLK);
      DATA1 = 8'd100; DATA2 = 8'd7; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      repeat (3) @(negedge CLK);
      RESET = 1'b0;
      #1;
      check("abort_quotient", int'(QUOTIENT), 0);
      check("abort_remainder", int'(REMAINDER), 0);
      check("abort_busy", int'(BUSY), 0);
      check("abort_flags_done", int'({DIV_BY_ZERO, OVERFLOW, DONE}), 0);
      @(negedge CLK);
      @(negedge CLK);
      RESET = 1'b1;
      done_seen = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge CLK);
         if (DONE || BUSY) done_seen++;
      end
      check("abort_no_done", done_seen, 0);
      run_div(8'd20, 8'd4, 1'b0, lat, busy_cnt);
      check_result("after_abort", 8'd5, 8'd0, 1'b0, 1'b0);

      // Randomized against the arithmetic model, with operand/START noise
      // while the divider is busy.
      for (int i = 0; i < 300; i++) begin
         a = 8'($urandom);
         b = 8'($urandom);
         case ($urandom_range(0, 9))
            0: b = 8'h00;
            1: b = 8'hFF;
            2: a = 8'h80;
            3: b = 8'h01;
            default: ;
         endcase
         model(a, b, eq, er, edbz, eov, elat);
         run_div(a, b, 1'b1, lat, busy_cnt);
         check_result($sformatf("rnd%0d_%0h_%0h", i, a, b), eq, er, edbz, eov);
         check($sformatf("rnd%0d_latency", i), lat, elat);
         check($sformatf("rnd%0d_busy_cycles", i), busy_cnt, elat);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
